// File: rtl/fixed_matmul_pkg.sv
// Shared types and helpers for the matmul weight replayer.
//
// Contents:
//   replay_state_t : FSM encoding of the replayer (FILL, REPLAY)
//   clog2_min1     : counter width helper; never returns less than 1
package fixed_matmul_pkg;

    typedef enum logic {
        FILL   = 1'b0,
        REPLAY = 1'b1
    } replay_state_t;

    // Counter width for a modulus of n. A modulus of 1 still needs a 1-bit
    // counter so the declarations never collapse to zero width.
    function automatic int clog2_min1(input int n);
        int w;
        w = (n <= 1) ? 1 : $clog2(n);
        return w;
    endfunction

endpackage

// File: rtl/weight_replay_buffer.sv
// Register file that holds one right-operand column block.
//
// One synchronous write port and one asynchronous read port, so the
// replayer can present buf[rd_ptr] on the same cycle the pointer moves.
// The contents are not reset; the FSM never reads an entry it has not
// written in the current block.
//
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data (one beat)
//   raddr  in   read address
//   rdata  out  read data (combinational from raddr)
module weight_replay_buffer
    import fixed_matmul_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int DW    = 24
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [clog2_min1(DEPTH)-1:0]  waddr,
    input  logic [DW-1:0]                 wdata,
    input  logic [clog2_min1(DEPTH)-1:0]  raddr,
    output logic [DW-1:0]                 rdata
);

    localparam int AW = clog2_min1(DEPTH);
    // Sized to the full address range so every index is in bounds even when
    // DEPTH is not a power of two; entries at or above DEPTH are never written.
    localparam int ENTRIES = 1 << AW;

    logic [DW-1:0] mem_r [ENTRIES];

    // Write port: store the beat on the write strobe.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/fixed_matmul_weight_replayer.sv
// Weight replayer in front of the matmul core's data_in2 stream.
//
// Captures IN_DEPTH beats of IN_SIZE*PARALLELISM elements (one column
// block of the right operand) and then replays that block REPEAT times in
// beat order, one pass per row block of data_in1. Filling and replaying
// never overlap: the source is held off while the block is being replayed.
//
// Optional feature (macro WEIGHT_REPLAY_PASSTHROUGH_EN):
//   When defined, pass 0 streams straight through while the block fills
//   (data_out = data_in, valid/ready wired combinationally source->sink),
//   the buffer is written on the joint handshake and only REPEAT-1 replay
//   passes follow. When undefined, there is no combinational path from
//   inputs to outputs and all REPEAT passes come from the buffer.
//
// Ports:
//   clk            in   clock
//   rst            in   synchronous active-high reset
//   data_in        in   incoming weight beat (IN_SIZE*PARALLELISM x WIDTH)
//   data_in_valid  in   source beat valid
//   data_in_ready  out  block accepts a beat
//   data_out       out  beat to matmul data_in2
//   data_out_valid out  output beat valid
//   data_out_ready in   consumer accepts the beat
//   data_out_last  out  high with the final beat of the final pass
module fixed_matmul_weight_replayer
    import fixed_matmul_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int IN_SIZE     = 1,
    parameter int PARALLELISM = 3,
    parameter int IN_DEPTH    = 3,
    parameter int REPEAT      = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [IN_SIZE*PARALLELISM-1:0][WIDTH-1:0] data_in,
    input  logic                                     data_in_valid,
    output logic                                     data_in_ready,
    output logic [IN_SIZE*PARALLELISM-1:0][WIDTH-1:0] data_out,
    output logic                                     data_out_valid,
    input  logic                                     data_out_ready,
    output logic                                     data_out_last
);

    localparam int NELEM  = IN_SIZE * PARALLELISM;
    localparam int BEAT_W = NELEM * WIDTH;
    localparam int PTR_W  = clog2_min1(IN_DEPTH);
    localparam int PASS_W = clog2_min1(REPEAT);

    localparam logic [PTR_W-1:0]  LAST_BEAT = PTR_W'(IN_DEPTH - 1);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(REPEAT - 1);

    replay_state_t      state_r;
    replay_state_t      state_s;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_s;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_s;
    logic [PASS_W-1:0]  pass_r;
    logic [PASS_W-1:0]  pass_s;

    logic               buf_we_s;
    logic [BEAT_W-1:0]  buf_wdata_s;
    logic [BEAT_W-1:0]  buf_rdata_s;

    logic               in_hs_s;
    logic               out_hs_s;
    logic               wr_last_s;
    logic               rd_last_s;
    logic               pass_last_s;

    assign wr_last_s   = (wr_ptr_r == LAST_BEAT);
    assign rd_last_s   = (rd_ptr_r == LAST_BEAT);
    assign pass_last_s = (pass_r == LAST_PASS);
    assign buf_wdata_s = data_in;

    weight_replay_buffer #(
        .DEPTH (IN_DEPTH),
        .DW    (BEAT_W)
    ) u_buffer (
        .clk   (clk),
        .we    (buf_we_s),
        .waddr (wr_ptr_r),
        .wdata (buf_wdata_s),
        .raddr (rd_ptr_r),
        .rdata (buf_rdata_s)
    );

    // Stream-side outputs and handshakes, decoded from the current state.
    always_comb begin
        data_in_ready  = 1'b0;
        data_out_valid = 1'b0;
        data_out_last  = 1'b0;
        data_out       = buf_rdata_s;
        case (state_r)
            FILL: begin
`ifdef WEIGHT_REPLAY_PASSTHROUGH_EN
                // Pass 0 flows through; pass_r is 0 in FILL, so pass_last_s
                // here means the block is only ever sent once.
                data_out       = data_in;
                data_out_valid = data_in_valid;
                data_in_ready  = data_out_ready;
                data_out_last  = data_in_valid & wr_last_s & pass_last_s;
`else
                data_in_ready  = 1'b1;
`endif
            end
            REPLAY: begin
                data_out_valid = 1'b1;
                data_out_last  = rd_last_s & pass_last_s;
            end
            default: begin
                data_in_ready  = 1'b0;
                data_out_valid = 1'b0;
            end
        endcase
        in_hs_s  = data_in_valid & data_in_ready;
        out_hs_s = data_out_valid & data_out_ready;
    end

    // Next-state, pointer and pass-counter logic.
    always_comb begin
        state_s  = state_r;
        wr_ptr_s = wr_ptr_r;
        rd_ptr_s = rd_ptr_r;
        pass_s   = pass_r;
        buf_we_s = 1'b0;
        case (state_r)
            FILL: begin
                if (in_hs_s) begin
                    buf_we_s = 1'b1;
                    if (wr_last_s) begin
                        wr_ptr_s = {PTR_W{1'b0}};
`ifdef WEIGHT_REPLAY_PASSTHROUGH_EN
                        // Pass 0 has already gone out with the fill.
                        if (pass_last_s) begin
                            state_s = FILL;
                        end else begin
                            state_s = REPLAY;
                            pass_s  = PASS_W'(1);
                        end
`else
                        state_s = REPLAY;
`endif
                    end else begin
                        wr_ptr_s = wr_ptr_r + PTR_W'(1);
                    end
                end else begin
                    wr_ptr_s = wr_ptr_r;
                end
            end
            REPLAY: begin
                if (out_hs_s) begin
                    if (rd_last_s) begin
                        rd_ptr_s = {PTR_W{1'b0}};
                        if (pass_last_s) begin
                            pass_s  = {PASS_W{1'b0}};
                            state_s = FILL;
                        end else begin
                            pass_s  = pass_r + PASS_W'(1);
                        end
                    end else begin
                        rd_ptr_s = rd_ptr_r + PTR_W'(1);
                    end
                end else begin
                    rd_ptr_s = rd_ptr_r;
                end
            end
            default: begin
                state_s  = FILL;
                wr_ptr_s = {PTR_W{1'b0}};
                rd_ptr_s = {PTR_W{1'b0}};
                pass_s   = {PASS_W{1'b0}};
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= FILL;
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            pass_r   <= {PASS_W{1'b0}};
        end else begin
            state_r  <= state_s;
            wr_ptr_r <= wr_ptr_s;
            rd_ptr_r <= rd_ptr_s;
            pass_r   <= pass_s;
        end
    end

endmodule
